// File: rtl/ibex_counter_ctrl.sv
// Register-access and event front end for a 64-bit ibex_counter.
// Optional coherent high-half read via IBEX_COUNTER_CTRL_SNAPSHOT_EN.
module ibex_counter_ctrl #(
    parameter int unsigned PrescaleWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic                     req_hi_i,
    input  logic [31:0]              req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_rdata_o,
    input  logic                     event_i,
    input  logic                     inhibit_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    output logic                     counter_inc_o,
    output logic                     counter_we_o,
    output logic                     counterh_we_o,
    output logic [31:0]              counter_wdata_o,
    input  logic [63:0]              counter_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RSP
    } state_t;

    state_t state, state_next;

    logic                     accept;
    logic                     accept_wr;
    logic                     accept_rd;
    logic                     event_cycle;
    logic                     fire;
    logic [PrescaleWidth-1:0] pcnt;
    logic [31:0]              rdata_sel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_next = req_write_i ? WR : RSP;
                end
            end
            WR:      state_next = RSP;
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept    = req_valid_i && (state == IDLE);
    assign accept_wr = accept && req_write_i;
    assign accept_rd = accept && !req_write_i;

`ifdef IBEX_COUNTER_CTRL_SNAPSHOT_EN
    logic [31:0] snap;
    logic        snap_valid;

    // A low read captures the high half so the following high read pairs with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap       <= '0;
            snap_valid <= 1'b0;
        end else if (accept_wr) begin
            snap_valid <= 1'b0;
        end else if (accept_rd) begin
            if (req_hi_i) begin
                snap_valid <= 1'b0;
            end else begin
                snap       <= counter_rdata_i[63:32];
                snap_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = counter_rdata_i[31:0];
        if (req_hi_i) begin
            rdata_sel = snap_valid ? snap : counter_rdata_i[63:32];
        end
    end
`else
    always_comb begin
        rdata_sel = req_hi_i ? counter_rdata_i[63:32] : counter_rdata_i[31:0];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            counter_we_o    <= 1'b0;
            counterh_we_o   <= 1'b0;
            counter_wdata_o <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_rdata_o     <= '0;
        end else begin
            counter_we_o  <= accept_wr && !req_hi_i;
            counterh_we_o <= accept_wr && req_hi_i;
            rsp_valid_o   <= (state_next == RSP);
            if (accept_wr) begin
                counter_wdata_o <= req_wdata_i;
                rsp_rdata_o     <= '0;
            end else if (accept_rd) begin
                rsp_rdata_o <= rdata_sel;
            end
        end
    end

    // Events landing in the write-strobe cycle are dropped outright; an increment
    // that would coincide with the strobe is suppressed so the write wins.
    assign event_cycle = event_i && !inhibit_i && (state != WR);
    assign fire        = event_cycle && (pcnt >= prescale_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt          <= '0;
            counter_inc_o <= 1'b0;
        end else begin
            counter_inc_o <= fire && !accept_wr;
            if (event_cycle) begin
                pcnt <= fire ? '0 : pcnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/ibex_counter_ctrl.md
# ibex_counter_ctrl

Access and event front end for one 64-bit `ibex_counter` instance: converts a 32-bit request/response register interface and a raw event strobe into the counter's write strobes, write data and increment pulse, and returns counter reads. Sits directly upstream of the counter, driving its inputs, and also consumes its 64-bit value for the read path. An optional high-half snapshot makes a low-then-high read pair coherent.

## Interface
- `PrescaleWidth`, 8, width of the event prescaler count and of `prescale_i`.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  request ready; high only in state IDLE.
- `req_write_i`  in  1  1 selects write, 0 selects read.
- `req_hi_i`  in  1  1 selects bits [63:32], 0 selects bits [31:0].
- `req_wdata_i`  in  32  write data.
- `rsp_valid_o`  out  1  one-cycle response pulse; there is no response back-pressure.
- `rsp_rdata_o`  out  32  read data, valid only while `rsp_valid_o` is high; 0 for writes.
- `event_i`  in  1  raw event, one event per high cycle.
- `inhibit_i`  in  1  suppresses counting; the prescaler holds its count.
- `prescale_i`  in  PrescaleWidth  one increment per `prescale_i`+1 events.
- `counter_inc_o`  out  1  to `counter_inc_i`.
- `counter_we_o`  out  1  to `counter_we_i`.
- `counterh_we_o`  out  1  to `counterh_we_i`.
- `counter_wdata_o`  out  32  to `counter_val_i`.
- `counter_rdata_i`  in  64  from `counter_val_o`.

## Operation
- FSM states: IDLE, WR, RSP.
- IDLE: on `req_valid_i`, go to WR if `req_write_i` is 1, otherwise go to RSP.
- WR: lasts exactly 1 cycle, then go to RSP.
- RSP: lasts exactly 1 cycle, then go to IDLE.
- Write accept: register `req_wdata_i` into `counter_wdata_o` and register `req_hi_i`.
  - In WR, `counter_we_o` is high for a low-half write; `counterh_we_o` is high for a high-half write. Exactly one of them is high.
- Read accept: sample `counter_rdata_i` at the accept edge into `rsp_rdata_o`.
  - Low read returns [31:0]; high read returns [63:32], or the snapshot (see Configuration).
- `counter_wdata_o` holds its last written value until the next write.
- Prescaler, with register `pcnt` (PrescaleWidth bits):
  - An event cycle is one with `event_i`=1 and `inhibit_i`=0.
  - On an event cycle with `pcnt` >= `prescale_i`: `pcnt` <= 0 and `counter_inc_o` <= 1.
  - On any other event cycle: `pcnt` <= `pcnt`+1 and `counter_inc_o` <= 0.
  - The >= compare means lowering `prescale_i` below `pcnt` fires on the next event.
  - `prescale_i`=0 gives one increment per event.
- Write priority: in the WR cycle, `counter_inc_o` is forced to 0. An event in the WR cycle is dropped and `pcnt` is unchanged.
- Events and register traffic are otherwise independent; neither stalls the other.
- Reset values:
  - State IDLE, so `req_ready_o`=1.
  - `rsp_valid_o`, `rsp_rdata_o`, `counter_inc_o`, `counter_we_o`, `counterh_we_o` and `counter_wdata_o` are all 0.
  - `pcnt`=0 and the snapshot is cleared.
  - Requests and events are ignored while `rst_i` is high.
- Reset mid-transaction aborts it. No strobe or response is produced after the reset edge.

## Timing
- Request handshake completes on an edge where `req_valid_i` and `req_ready_o` are both high.
- Read accepted at edge E: `rsp_valid_o` is high in the cycle after E. The next accept is possible at E+2.
- Write accepted at edge E: strobe in cycle E+1, `rsp_valid_o` in cycle E+2. The counter holds the new value from E+2. The next accept is possible at E+3.
- Event in cycle N with the prescaler expiring: `counter_inc_o` high in cycle N+1; the counter shows +1 in cycle N+2.
- `counter_inc_o`, `counter_we_o` and `counterh_we_o` are registered single-cycle pulses.

## Configuration
- Macro: `IBEX_COUNTER_CTRL_SNAPSHOT_EN`.
- Defined:
  - A low-half read also latches `counter_rdata_i[63:32]` into a snapshot and sets `snap_valid`.
  - A high-half read with `snap_valid` set returns the snapshot and clears `snap_valid`.
  - A high-half read with `snap_valid` clear returns the live value.
  - Any write and reset clear `snap_valid`.
- Undefined: no snapshot storage exists and high-half reads always return live [63:32].

## Test plan
- Reset, then write the low half with 0x0000_00FF → `counter_we_o` high for 1 cycle, `counter_wdata_o`=0xFF, `rsp_valid_o` 2 cycles after accept; a following low read returns 0xFF.
- `prescale_i`=3, 8 event cycles with `inhibit_i` low → exactly 2 `counter_inc_o` pulses, after events 4 and 8; the counter reads 2.
- Event in the same cycle as a WR strobe with `prescale_i`=0 → no `counter_inc_o`; the counter equals the written value.
- Counter at 0x0000_0000_FFFF_FFFF, low read, then one increment, then high read → with the macro the high read returns 0x0; without it, 0x1.
- `inhibit_i`=1 during 5 events, then 1 event with `prescale_i`=0 → exactly 1 increment; `pcnt` did not advance while inhibited.
- `rst_i` asserted in the WR cycle → no response pulse; all outputs are 0 and `req_ready_o`=1 the cycle after reset is released.
